prod_accumulator: RTL and testbench
===================================

# prod_accumulator

Accumulates the registered 18-bit products of the 9x9 approximate multiplier over a frame of beats into a wide two's-complement sum. Sits directly downstream of the multiplier's output register. Uses a valid/ready handshake on both sides and reports per-frame beat count and a sticky overflow flag. Feeds the DSP output/writeback stage.

## Interface
Parameters:
- ACC_W, 32, accumulator width in bits; legal range 19..48.
- CNT_W, 8, beat counter width in bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- prod_in  in  18  product from the multiplier output register.
- prod_signed  in  1  1: prod_in is two's complement (the multiplier had signA|signB set); 0: unsigned.
- in_valid  in  1  prod_in/prod_signed/in_last are valid.
- in_last  in  1  this beat is the last of the frame.
- in_ready  out  1  accumulator can accept a beat.
- acc_out  out  ACC_W  frame sum, two's complement.
- acc_count  out  CNT_W  beats accepted in the frame; saturates at all-ones.
- overflow  out  1  sticky per frame; signed overflow occurred.
- out_valid  out  1  acc_out/acc_count/overflow hold a completed frame.
- out_ready  in  1  downstream accepts the result.

## Operation
- Beat accepted when in_valid & in_ready.
- Extension: prod_signed=1 sign-extends prod_in[17]; prod_signed=0 zero-extends. The accumulator is always treated as signed.
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready=1, out_valid=0. An accepted beat loads acc=ext(prod_in), count=1, overflow=0. Next state is DONE if in_last, else ACC.
- ACC: in_ready=1. An accepted beat adds ext(prod_in) and increments count, saturating at 2^CNT_W-1. Next state is DONE on in_last. With no beat accepted, the state holds.
- DONE: in_ready=0, out_valid=1, outputs stable. out_ready=1 moves to IDLE.
- in_ready is decoded combinationally from the state only, never from out_ready.
- Overflow is detected as signed overflow of the add: both operands have the same sign and the sum sign differs. It sets `overflow`, which stays set until the next frame's first beat.
- acc_out, acc_count and overflow keep their last values after the handshake, until the next frame's first beat.

## Timing
- Reset values: state=IDLE, acc_out=0, acc_count=0, overflow=0, out_valid=0. in_ready=1 (follows IDLE), including while reset is asserted.
- Throughput: 1 beat/cycle within a frame.
- Latency: the last beat accepted at edge N gives out_valid=1 in the cycle after edge N.
- Inter-frame gap: at least one cycle (DONE). A beat presented during DONE is not accepted. It is accepted in IDLE on the following cycle.
- If out_valid=1 and out_ready=1 at edge M: out_valid=0 and in_ready=1 after M.
- Single-beat frame (in_last on the first beat): IDLE goes directly to DONE, count=1.
- Reset asserted mid-frame: the partial sum is discarded immediately and all outputs go to their reset values.
- in_valid=0 in ACC: idle cycles inserted; the sum is unchanged.

## Configuration
- APIR_ACC_SAT_EN defined: on overflow, acc saturates to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). The sum then continues from the clamped value. overflow is set.
- APIR_ACC_SAT_EN undefined: the sum wraps modulo 2^ACC_W. overflow is set.

## Test plan
- Single unsigned beat 0x0FE01 (prod_signed=0, in_last=1) -> next cycle out_valid=1, acc_out=65025, acc_count=1, overflow=0.
- Signed frame 0x3FF01(-255), 0x00064(100), 0x0000A(10, last), back-to-back -> acc_out=0xFFFFFF6F (-145), acc_count=3; out_valid one cycle after the last beat.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, no beat accepted, acc_out stable. Raise out_ready -> out_valid drops next cycle; the pending beat is accepted one cycle later as a fresh frame.
- ACC_W=20, nine unsigned beats of 0x0FE01 -> overflow=1, acc_count=9; acc_out=-463351 (0x8EE09) without the macro, 0x7FFFF with APIR_ACC_SAT_EN.
- Reset pulse after two accepted beats of a frame -> all outputs zero, in_ready=1. New frame with one beat 0x00005 (last) -> acc_out=5, acc_count=1, overflow=0.
- 300-beat unsigned frame of 0x00001 with CNT_W=8 -> acc_count saturates at 255, acc_out=300.

Source files
------------

// File: rtl/prod_accumulator.sv
// Frame accumulator for the 9x9 multiplier's registered 18-bit products, with beat count and sticky overflow.
// Optional APIR_ACC_SAT_EN: clamp the sum on signed overflow instead of wrapping.
module prod_accumulator #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [17:0]      prod_in,
  input  logic             prod_signed,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nxt;

  logic             take;
  logic [ACC_W-1:0] ext, sum, acc_add;
  logic             add_ovf;

  assign ext     = {{(ACC_W-18){prod_signed & prod_in[17]}}, prod_in};
  assign sum     = acc_out + ext;
  assign add_ovf = (acc_out[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_out[ACC_W-1]);

`ifdef APIR_ACC_SAT_EN
  // Both operands share a sign on overflow, so the accumulator sign picks the rail.
  always_comb begin
    acc_add = sum;
    if (add_ovf)
      acc_add = acc_out[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_add = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = in_last ? DONE : ACC;
      ACC:     if (take && in_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready depends on state alone, never on out_ready.
  always_comb begin
    in_ready  = (state == IDLE) || (state == ACC);
    out_valid = (state == DONE);
    take      = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_out   <= '0;
      acc_count <= '0;
      overflow  <= 1'b0;
    end else if (take) begin
      if (state == IDLE) begin
        acc_out   <= ext;
        acc_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        overflow  <= 1'b0;
      end else begin
        acc_out <= acc_add;
        if (acc_count != {CNT_W{1'b1}}) acc_count <= acc_count + 1'b1;
        if (add_ovf) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: a 32-bit and a 20-bit instance driven by the same stimulus.
module tb_prod_accumulator;
  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] prod_in;
  logic        prod_signed, in_valid, in_last, out_ready;

  logic        in_ready_a, ovf_a, ov_a;
  logic [31:0] acc_a;
  logic [7:0]  cnt_a;
  logic        in_ready_b, ovf_b, ov_b;
  logic [19:0] acc_b;
  logic [7:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prod_accumulator #(.ACC_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_signed(prod_signed),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
    .acc_out(acc_a), .acc_count(cnt_a), .overflow(ovf_a), .out_valid(ov_a),
    .out_ready(out_ready));

  prod_accumulator #(.ACC_W(20), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .prod_in(prod_in), .prod_signed(prod_signed),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
    .acc_out(acc_b), .acc_count(cnt_b), .overflow(ovf_b), .out_valid(ov_b),
    .out_ready(out_ready));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [17:0] p, input logic s, input logic v, input logic l);
    prod_in = p; prod_signed = s; in_valid = v; in_last = l;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] ovf_exp;
`ifdef APIR_ACC_SAT_EN
    ovf_exp = 64'h7FFFF;
`else
    ovf_exp = 64'h8EE09;
`endif
    reset = 1'b1; out_ready = 1'b0;
    drive(18'h0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rst_acc", acc_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_oval", ov_a, 0);
    chk("rst_irdy", in_ready_a, 1);
    step; reset = 1'b1;

    // single unsigned beat
    drive(18'h0FE01, 1'b0, 1'b1, 1'b1);
    step;
    chk("one_oval", ov_a, 1);
    chk("one_acc", acc_a, 65025);
    chk("one_cnt", cnt_a, 1);
    chk("one_ovf", ovf_a, 0);
    chk("one_irdy", in_ready_a, 0);
    drive(18'h0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    step;
    chk("one_hs_oval", ov_a, 0);
    chk("one_hs_irdy", in_ready_a, 1);
    chk("one_hs_hold", acc_a, 65025);
    out_ready = 1'b0;

    // signed frame, back-to-back
    drive(18'h3FF01, 1'b1, 1'b1, 1'b0); step;
    drive(18'h00064, 1'b1, 1'b1, 1'b0); step;
    chk("sgn_mid_oval", ov_a, 0);
    drive(18'h0000A, 1'b1, 1'b1, 1'b1); step;
    chk("sgn_oval", ov_a, 1);
    chk("sgn_acc", acc_a, 64'hFFFFFF6F);
    chk("sgn_acc20", acc_b, 64'hFFF6F);
    chk("sgn_cnt", cnt_a, 3);

    // backpressure in DONE with a beat pending
    drive(18'h00007, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_irdy", in_ready_a, 0);
      chk("bp_oval", ov_a, 1);
      chk("bp_acc", acc_a, 64'hFFFFFF6F);
    end
    out_ready = 1'b1;
    step;
    chk("bp_rel_oval", ov_a, 0);
    chk("bp_rel_irdy", in_ready_a, 1);
    chk("bp_rel_acc", acc_a, 64'hFFFFFF6F);
    out_ready = 1'b0;
    step;
    chk("bp_new_oval", ov_a, 1);
    chk("bp_new_acc", acc_a, 7);
    chk("bp_new_cnt", cnt_a, 1);
    drive(18'h0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    step; out_ready = 1'b0;

    // nine unsigned beats with an idle gap; the 20-bit instance overflows
    for (int i = 0; i < 4; i++) begin
      drive(18'h0FE01, 1'b0, 1'b1, 1'b0); step;
    end
    drive(18'h0, 1'b0, 1'b0, 1'b0);
    step; step;
    chk("gap_oval", ov_a, 0);
    chk("gap_acc20", acc_b, 64'h3F804);
    chk("gap_cnt", cnt_b, 4);
    for (int i = 4; i < 9; i++) begin
      drive(18'h0FE01, 1'b0, 1'b1, (i == 8)); step;
    end
    chk("ov_oval", ov_b, 1);
    chk("ov_flag20", ovf_b, 1);
    chk("ov_cnt20", cnt_b, 9);
    chk("ov_acc20", acc_b, ovf_exp);
    chk("ov_acc32", acc_a, 585225);
    chk("ov_flag32", ovf_a, 0);
    drive(18'h0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    step;
    chk("ov_sticky", ovf_b, 1);
    chk("ov_hs_oval", ov_b, 0);
    out_ready = 1'b0;

    // reset mid-frame
    drive(18'h00011, 1'b0, 1'b1, 1'b0); step; step;
    drive(18'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("mrst_acc", acc_a, 0);
    chk("mrst_cnt", cnt_a, 0);
    chk("mrst_ovf", ovf_b, 0);
    chk("mrst_oval", ov_a, 0);
    chk("mrst_irdy", in_ready_a, 1);
    step; reset = 1'b1;
    drive(18'h00005, 1'b0, 1'b1, 1'b1); step;
    chk("mrst_new_acc", acc_a, 5);
    chk("mrst_new_cnt", cnt_a, 1);
    chk("mrst_new_ovf", ovf_a, 0);
    chk("mrst_new_oval", ov_a, 1);
    drive(18'h0, 1'b0, 1'b0, 1'b0); out_ready = 1'b1;
    step; out_ready = 1'b0;

    // 300-beat frame: count saturates, sum does not
    for (int i = 1; i <= 300; i++) begin
      drive(18'h00001, 1'b0, 1'b1, (i == 300)); step;
      if (i == 150) chk("sat_mid_oval", ov_a, 0);
    end
    drive(18'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", cnt_a, 255);
    chk("sat_acc", acc_a, 300);
    chk("sat_ovf20", ovf_b, 0);
    chk("sat_oval", ov_a, 1);
    out_ready = 1'b1;
    step; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
